// File: rtl/siaa_pkg.sv
// Shared types and constants for the bit stream reader.
// Holds the FSM state enum, byte width and default bit-address width.
package siaa_pkg;

   localparam int BYTE_W     = 8;
   localparam int BSR_ADDR_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      STREAM,
      DONE
   } bsr_state_e;

endpackage

// File: rtl/bit_stream_reader.sv
// Streams memory bits MSB-first from a bit address over valid/ready.
// Ports: clk, rst_n (async, active-low); start/base_addr/len request;
//   busy, done status; mem_rd/mem_addr/mem_rdata sync byte memory;
//   bit_out/bit_valid/bit_ready stream; parity of accepted bits.
// Option: define BSR_PARITY_EN for the running parity register,
//   otherwise parity is tied low.
module bit_stream_reader
   import siaa_pkg::*;
#(
   parameter int ADDR_W = BSR_ADDR_W,
   parameter int LEN_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              mem_rd,
   output logic [ADDR_W-4:0] mem_addr,
   input  logic [BYTE_W-1:0] mem_rdata,
   output logic              bit_out,
   output logic              bit_valid,
   input  logic              bit_ready,
   output logic              done,
   output logic              parity
);

   bsr_state_e        r_state;
   bsr_state_e        w_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [LEN_W-1:0]  r_rem;
   logic [BYTE_W-1:0] r_byte;
   logic              w_take;
   logic              w_accept;

   assign w_take   = (r_state == IDLE) && start;
   assign w_accept = (r_state == STREAM) && bit_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b1;
      mem_rd    = 1'b0;
      bit_valid = 1'b0;
      done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next = (len == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            mem_rd = 1'b1;
            w_next = WAIT;
         end
         WAIT: begin
            w_next = STREAM;
         end
         STREAM: begin
            bit_valid = 1'b1;
            if (bit_ready) begin
               if (r_rem == LEN_W'(1)) begin
                  w_next = DONE;
               end else if (r_ptr[2:0] == 3'd7) begin
                  // next bit lives in the following byte
                  w_next = FETCH;
               end
            end
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= '0;
         r_rem  <= '0;
         r_byte <= '0;
      end else begin
         if (w_take) begin
            r_ptr <= base_addr;
            r_rem <= len;
         end else if (w_accept) begin
            // wraps naturally at the top of the address space
            r_ptr <= r_ptr + 1'b1;
            r_rem <= r_rem - 1'b1;
         end
         if (r_state == WAIT) begin
            r_byte <= mem_rdata;
         end
      end
   end

   assign mem_addr = r_ptr[ADDR_W-1:3];
   // offset 0 selects the byte MSB
   assign bit_out  = bit_valid & r_byte[3'd7 - r_ptr[2:0]];

`ifdef BSR_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (w_take) begin
         r_parity <= 1'b0;
      end else if (w_accept && bit_out) begin
         r_parity <= ~r_parity;
      end
   end

   assign parity = r_parity;
`else
   assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_bit_stream_reader.sv
// Self-checking bench for bit_stream_reader.
// Reference model builds expected bits/reads from a memory image.
module tb_bit_stream_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] base_addr = '0;
   logic [4:0] len = '0;
   logic       busy;
   logic       mem_rd;
   logic [5:0] mem_addr;
   logic [7:0] mem_rdata = '0;
   logic       bit_out;
   logic       bit_valid;
   logic       bit_ready = 1'b1;
   logic       done;
   logic       parity;

   bit_stream_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .done      (done),
      .parity    (parity)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [64];

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   int ncmp = 0;
   int nbad = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   bit         exp_q [$];
   int         rd_q [$];
   int         acc_q [$];
   bit         exp_par;
   logic [31:0] rx;
   int         rxn;
   int         done_cnt = 0;
   int         done_cyc;
   int         first_v;
   int         start_cyc;
   int         stall_idx = -1;
   int         stall_left = 0;
   logic       hold_pend = 1'b0;
   logic       hold_bit;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      ncmp++;
      if (got !== want) begin
         nbad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, got, want, cyc);
      end
   endtask

   // model: expected bit sequence and byte reads from the memory image
   task automatic prep(input int base, input int n);
      int a;
      logic [7:0] v;
      exp_q.delete();
      rd_q.delete();
      acc_q.delete();
      exp_par = 1'b0;
      rx = '0;
      rxn = 0;
      first_v = -1;
      for (int i = 0; i < n; i++) begin
         a = (base + i) % 512;
         if (i == 0 || a % 8 == 0) rd_q.push_back(a / 8);
         v = mem[a / 8];
         exp_q.push_back(v[7 - (a % 8)]);
         exp_par = exp_par ^ v[7 - (a % 8)];
      end
   endtask

   // compare process
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (!busy) begin
            chk("idle_rd", mem_rd, 0);
            chk("idle_valid", bit_valid, 0);
            chk("idle_done", done, 0);
         end
         if (mem_rd) begin
            chk("rd_expected", 32'(rd_q.size() != 0), 1);
            if (rd_q.size() != 0) chk("rd_addr", mem_addr, rd_q.pop_front());
         end
         if (hold_pend) begin
            chk("hold_valid", bit_valid, 1);
            chk("hold_bit", bit_out, hold_bit);
         end
         hold_pend = bit_valid && !bit_ready;
         hold_bit = bit_out;
         if (bit_valid && first_v < 0) first_v = cyc;
         if (bit_valid && bit_ready) begin
            chk("bit_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("bit_val", bit_out, exp_q.pop_front());
            rx = {rx[30:0], bit_out};
            rxn++;
            acc_q.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy", busy, 1);
            chk("done_all_bits", exp_q.size(), 0);
`ifdef BSR_PARITY_EN
            chk("parity", parity, exp_par);
`else
            chk("parity", parity, 0);
`endif
         end
      end
   end

   // consumer: optionally stalls on a chosen bit index
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (stall_left > 0 && bit_valid && rxn == stall_idx) begin
            bit_ready = 1'b0;
            stall_left--;
         end else begin
            bit_ready = 1'b1;
         end
      end
   end

   task automatic req(input int base, input int n, input int st_idx,
                      input int st_n, input bit poke);
      int t;
      int d0;
      prep(base, n);
      stall_idx = st_idx;
      stall_left = st_n;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 9'(base);
      len = 5'(n);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      start = 1'b0;
      base_addr = 9'($urandom);
      len = 5'($urandom);
      if (poke) begin
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      t = 0;
      while (done_cnt == d0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk("done_seen", 32'(done_cnt != d0), 1);
      @(posedge clk);
      #1;
      chk("done_once", done_cnt, d0 + 1);
      chk("rd_all", rd_q.size(), 0);
      chk("bit_count", rxn, n);
      chk("idle_after", busy, 0);
   endtask

   initial begin
      int t;
      int d0;
      foreach (mem[i]) mem[i] = 8'h00;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_rd", mem_rd, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_valid", bit_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_bit", bit_out, 0);
      chk("rst_parity", parity, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single byte, mid-byte start
      mem[0] = 8'h05;
      req(5, 3, -1, 0, 1'b0);
      chk("t1_bits", rx[2:0], 3'b101);
      chk("t1_latency", first_v - start_cyc, 2);
      chk("t1_done_lat", done_cyc - acc_q[2], 1);

      // 2: byte crossing
      mem[31] = 8'h03;
      mem[32] = 8'h80;
      req(254, 4, -1, 0, 1'b0);
      chk("t2_bits", rx[3:0], 4'b1110);
      chk("t2_gap01", acc_q[1] - acc_q[0], 1);
      chk("t2_bubble", acc_q[2] - acc_q[1], 3);

      // 3: back-pressure on bit 2
      mem[0] = 8'hA5;
      req(0, 8, 2, 3, 1'b0);
      chk("t3_bits", rx[7:0], 8'hA5);
      chk("t3_stall", acc_q[2] - acc_q[1], 4);

      // 4: wrap from address 511 to 0
      mem[63] = 8'h01;
      mem[0] = 8'hC0;
      req(510, 4, -1, 0, 1'b0);
      chk("t4_bits", rx[3:0], 4'b0111);

      // 5: zero length, then start while busy
      req(100, 0, -1, 0, 1'b0);
      chk("t5_done_lat", done_cyc - start_cyc, 0);
      mem[0] = 8'h05;
      req(5, 3, -1, 0, 1'b1);
      chk("t5_poke_bits", rx[2:0], 3'b101);

      // 6: reset mid-request
      mem[2] = 8'h3C;
      prep(16, 8);
      d0 = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 9'd16;
      len = 5'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      t = 0;
      while (rxn < 2 && t < 100) begin
         @(posedge clk);
         t++;
      end
      chk("t6_reached", 32'(rxn >= 2), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_rd", mem_rd, 0);
      chk("t6_addr", mem_addr, 0);
      chk("t6_valid", bit_valid, 0);
      chk("t6_bit", bit_out, 0);
      chk("t6_done", done, 0);
      chk("t6_parity", parity, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      exp_q.delete();
      rd_q.delete();
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      chk("t6_no_done", done_cnt, d0);

      // recovery after reset, parity data has even weight
      mem[0] = 8'hA5;
      req(0, 8, -1, 0, 1'b0);
      chk("t6_bits", rx[7:0], 8'hA5);
      chk("t6_par_hold", parity, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
